life_frame_loader: RTL and testbench
====================================

// Module: life_frame_loader
// PURPOSE
//  Host-side front end for the 16x16 toroidal Life engine (Convay: clk, load, data[255:0], q[255:0]).
//  Collects a frame as 16 streamed rows, loads it into the engine with a one-cycle load pulse,
//  lets the engine run a requested number of generations, snapshots q, and streams the result
//  back out row by row. It is the driver/reader counterpart of the engine's load/data/q interface.
// PARAMETERS
//  SIDE   16  grid side; frame width SIDE*SIDE (engine is fixed at 16, other values unsupported)
//  GEN_W  8   width of run_gens
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  resetn     in   1      synchronous reset, active low
//  in_valid   in   1      input row valid
//  in_ready   out  1      input row ready
//  in_row     in   16     input row data, bit 15 = column 15
//  run_gens   in   GEN_W  generations to run; sampled on acceptance of the 16th row
//  life_load  out  1      to engine load
//  life_data  out  256    to engine data
//  life_q     in   256    from engine q
//  out_valid  out  1      result row valid
//  out_ready  in   1      result row ready
//  out_row    out  16     result row data
//  out_last   out  1      high with row 15
//  busy       out  1      high in every state except COLLECT
// BEHAVIOUR
//  - Row r maps to frame bits [255-16*r -: 16] (row 0 = MSBs) for life_data and life_q alike.
//  - Reset (resetn=0 at an edge, any state): state=COLLECT, row/out/gen counters=0, life_data=0,
//    snapshot=0, life_load=0, out_valid=0, out_row=0, out_last=0, busy=0, in_ready=1.
//    Partial frames and in-flight results are discarded.
//  - COLLECT: in_ready=1. On in_valid&in_ready, write in_row into slot row_cnt, then increment.
//    On row 15: gen_cnt<=run_gens; next state LOAD.
//  - LOAD (1 cycle): life_load=1, in_ready=0. life_data holds the frame from LOAD onward until the
//    next frame starts. Next state: RUN if gen_cnt!=0, else CAPTURE.
//  - RUN: life_load=0; decrement gen_cnt each cycle; leave for CAPTURE on the cycle gen_cnt==1.
//    RUN lasts exactly run_gens cycles, so life_q during CAPTURE = generation run_gens.
//  - CAPTURE (1 cycle): snapshot<=life_q; out_cnt<=0; next state DUMP.
//  - DUMP: out_valid=1, out_row=snapshot row out_cnt, out_last=(out_cnt==15). Advance on
//    out_valid&out_ready. out_row/out_last hold stable while stalled. After row 15 is accepted:
//    next state COLLECT, out_valid=0 in the next cycle, row_cnt=0.
//  - Latency: if the 16th row is accepted at edge E, out_valid rises run_gens+3 cycles after E.
//  - run_gens=0: output equals input frame (identity). run_gens=max (255) runs 255 generations.
//  - in_valid outside COLLECT is ignored (in_ready=0). No input rows are accepted during DUMP.
//  - Engine advances freely after CAPTURE; snapshot isolates the output from that.
//  - Registered outputs only; no combinational path from in_* or out_ready to any output.
// TESTING (bench instantiates Convay wired to life_*; rows listed 0..15; unlisted rows = 0)
//  1 Blinker: row7=16'h0380, gens=1 -> rows6,7,8=16'h0100; out_last only on row 15.
//  2 Identity: row r=16'h0001<<r, gens=0 -> output rows identical; out_valid at E+3.
//  3 Still life: rows0,1=16'h0003, gens=255 -> rows0,1=16'h0003; busy high 258 cycles before DUMP.
//  4 Wrap: row5=16'h8003, gens=1 -> rows4,5,6=16'h0001 (torus column wrap through engine).
//  5 Backpressure: out_ready high 1 in 3 cycles; in_valid held high throughout -> 16 rows in order,
//    out_row stable when stalled, in_ready=0 from LOAD until after row 15 accepted.
//  6 Reset in RUN (gens=20, resetn low 1 cycle at RUN cycle 5) -> next cycle all outputs at reset
//    values, in_ready=1; then test 1 frame yields test 1 result.

Source files
------------

// File: rtl/life_frame_loader.sv
// life_frame_loader: streams a 16-row frame into the Life engine, runs it for a requested
// number of generations, then streams the snapshot of the result back out row by row.
module life_frame_loader #(
  parameter int SIDE  = 16,
  parameter int GEN_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIDE-1:0]      in_row,
  input  logic [GEN_W-1:0]     run_gens,
  output logic                 life_load,
  output logic [SIDE*SIDE-1:0] life_data,
  input  logic [SIDE*SIDE-1:0] life_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIDE-1:0]      out_row,
  output logic                 out_last,
  output logic                 busy
);
  localparam int N = SIDE * SIDE;
  localparam int CW = $clog2(SIDE);
  localparam logic [CW-1:0] LAST = CW'(SIDE - 1);
  typedef enum logic [2:0] {COLLECT, LOAD, RUN, CAPTURE, DUMP} state_t;
  state_t state, state_n;
  logic [CW-1:0] row_cnt, out_cnt, out_nxt;
  logic [GEN_W-1:0] gen_cnt;
  logic [N-1:0] snapshot;
  logic in_fire, out_fire;
  function automatic logic [SIDE-1:0] row_of(input logic [N-1:0] v, input logic [CW-1:0] r);
    return v[N-1-SIDE*r -: SIDE];
  endfunction
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_nxt = out_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!resetn) state <= COLLECT;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      COLLECT: state_n = (in_fire && row_cnt == LAST) ? LOAD : COLLECT;
      LOAD:    state_n = (gen_cnt != '0) ? RUN : CAPTURE;
      RUN:     state_n = (gen_cnt == GEN_W'(1)) ? CAPTURE : RUN;
      CAPTURE: state_n = DUMP;
      DUMP:    state_n = (out_fire && out_last) ? COLLECT : DUMP;
      default: state_n = COLLECT;
    endcase
  end
  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_cnt   <= '0;
      out_cnt   <= '0;
      gen_cnt   <= '0;
      life_data <= '0;
      snapshot  <= '0;
      life_load <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      life_load <= state_n == LOAD;
      busy      <= state_n != COLLECT;
      in_ready  <= state_n == COLLECT;
      if (in_fire) begin
        life_data[N-1-SIDE*row_cnt -: SIDE] <= in_row;
        row_cnt <= row_cnt + 1'b1;
        if (row_cnt == LAST) gen_cnt <= run_gens;
      end
      if (state == RUN) gen_cnt <= gen_cnt - 1'b1;
      if (state == CAPTURE) begin
        snapshot <= life_q;
        out_cnt  <= '0;
      end
      // First DUMP cycle presents row 0; afterwards each accepted row advances the pointer.
      if (state == DUMP) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_row   <= row_of(snapshot, out_cnt);
          out_last  <= out_cnt == LAST;
        end else if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            row_cnt   <= '0;
          end else begin
            out_cnt  <= out_nxt;
            out_row  <= row_of(snapshot, out_nxt);
            out_last <= out_nxt == LAST;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_life_frame_loader.sv
// tb_life_frame_loader: drives frames through the loader wired to a behavioural Life engine
// and compares results against a grid-level reference model.
module tb_life_frame_loader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_row = '0;
  logic [7:0] run_gens = '0;
  logic life_load;
  logic [255:0] life_data;
  logic [255:0] life_q = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_row;
  logic out_last;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [15:0] frame_in[16];
  logic [15:0] exp_rows[16];
  logic [15:0] got[16];
  int lat;
  bit tmo, stab_bad, last_bad, busy_bad, inr_bad, post_bad, hold_valid;

  life_frame_loader #(.SIDE(16), .GEN_W(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .run_gens(run_gens), .life_load(life_load), .life_data(life_data), .life_q(life_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] eng_next(input logic [255:0] v);
    logic [255:0] n;
    int k;
    n = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) k += int'(v[240 - 16 * ((r + dr + 16) % 16) + (c + dc + 16) % 16]);
        n[240 - 16 * r + c] = (k == 3) || (k == 2 && v[240 - 16 * r + c]);
      end
    return n;
  endfunction

  always @(posedge clk) life_q <= life_load ? life_data : eng_next(life_q);

  task automatic model_run(input int g);
    bit grid[16][16];
    bit nx[16][16];
    int k;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) grid[r][c] = frame_in[r][c];
    repeat (g) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          k = 0;
          for (int dr = 15; dr <= 17; dr++)
            for (int dc = 15; dc <= 17; dc++)
              if (dr != 16 || dc != 16) k += int'(grid[(r + dr) % 16][(c + dc) % 16]);
          nx[r][c] = (k == 3) || (k == 2 && grid[r][c]);
        end
      grid = nx;
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) exp_rows[r][c] = grid[r][c];
  endtask

  task automatic clear_frame();
    for (int r = 0; r < 16; r++) frame_in[r] = '0;
  endtask

  task automatic send_frame(input logic [7:0] g);
    int n;
    for (int r = 0; r < 16; r++) begin
      n = 0;
      in_valid = 1'b1;
      in_row = frame_in[r];
      run_gens = g;
      while (in_ready !== 1'b1 && n < 500) begin
        @(posedge clk); #1; n++;
      end
      if (in_ready !== 1'b1) tmo = 1;
      @(posedge clk); #1;
    end
    if (!hold_valid) in_valid = 1'b0;
    in_row = 16'($urandom);
    run_gens = 8'($urandom);
  endtask

  task automatic receive(input int mode);
    int stall;
    logic [15:0] prev_row;
    logic prev_last;
    lat = 0; stab_bad = 0; last_bad = 0; busy_bad = 0; inr_bad = 0; post_bad = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (in_ready !== 1'b0) inr_bad = 1;
      @(posedge clk); #1; lat++;
    end
    if (out_valid !== 1'b1) begin
      tmo = 1;
      in_valid = 1'b0;
      return;
    end
    for (int r = 0; r < 16; r++) begin
      stall = 0;
      forever begin
        if (in_ready !== 1'b0) inr_bad = 1;
        if (busy !== 1'b1) busy_bad = 1;
        if (out_valid !== 1'b1) stab_bad = 1;
        if (hold_valid) in_row = 16'($urandom);
        out_ready = (mode == 0 || stall >= 6) ? 1'b1 : ($urandom_range(2) == 0);
        prev_row = out_row;
        prev_last = out_last;
        @(posedge clk); #1;
        if (out_ready) break;
        stall++;
        if (out_row !== prev_row || out_last !== prev_last) stab_bad = 1;
      end
      got[r] = prev_row;
      if (prev_last !== (r == 15)) last_bad = 1;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) post_bad = 1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (life_load !== 1'b0) begin errors++; $display("FAIL reset_life_load got %b want 0", life_load); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_out_flags got %b%b want 00", out_valid, out_last); end
    checks++; if (out_row !== 16'h0) begin errors++; $display("FAIL reset_out_row got %h want 0000", out_row); end
    checks++; if (life_data !== 256'h0) begin errors++; $display("FAIL reset_life_data got %h want 0", life_data); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_blinker();
    tmo = 0; hold_valid = 0;
    clear_frame();
    frame_in[7] = 16'h0380;
    send_frame(8'd1);
    receive(0);
    checks++; if (tmo) begin errors++; $display("FAIL blinker_timeout got 1 want 0"); end
    for (int r = 0; r < 16; r++) begin
      logic [15:0] e;
      e = (r >= 6 && r <= 8) ? 16'h0100 : 16'h0000;
      checks++; if (got[r] !== e) begin errors++; $display("FAIL blinker_row%0d got %h want %h", r, got[r], e); end
    end
    checks++; if (last_bad) begin errors++; $display("FAIL blinker_out_last got misplaced want row15 only"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL blinker_latency got %0d want 4", lat); end
    checks++; if (post_bad) begin errors++; $display("FAIL blinker_return_to_collect got bad want out_valid0 in_ready1"); end
  endtask

  task automatic test_identity();
    tmo = 0; hold_valid = 0;
    for (int r = 0; r < 16; r++) frame_in[r] = 16'h0001 << r;
    send_frame(8'd0);
    receive(0);
    checks++; if (tmo) begin errors++; $display("FAIL identity_timeout got 1 want 0"); end
    for (int r = 0; r < 16; r++) begin
      checks++; if (got[r] !== frame_in[r]) begin errors++; $display("FAIL identity_row%0d got %h want %h", r, got[r], frame_in[r]); end
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL identity_latency got %0d want 3", lat); end
  endtask

  task automatic test_still_life();
    tmo = 0; hold_valid = 0;
    clear_frame();
    frame_in[0] = 16'h0003;
    frame_in[1] = 16'h0003;
    send_frame(8'd255);
    receive(0);
    checks++; if (tmo) begin errors++; $display("FAIL still_timeout got 1 want 0"); end
    for (int r = 0; r < 16; r++) begin
      logic [15:0] e;
      e = (r < 2) ? 16'h0003 : 16'h0000;
      checks++; if (got[r] !== e) begin errors++; $display("FAIL still_row%0d got %h want %h", r, got[r], e); end
    end
    checks++; if (lat !== 258) begin errors++; $display("FAIL still_latency got %0d want 258", lat); end
    checks++; if (busy_bad) begin errors++; $display("FAIL still_busy got low want high through run"); end
  endtask

  task automatic test_wrap();
    tmo = 0; hold_valid = 0;
    clear_frame();
    frame_in[5] = 16'h8003;
    send_frame(8'd1);
    receive(0);
    checks++; if (tmo) begin errors++; $display("FAIL wrap_timeout got 1 want 0"); end
    for (int r = 0; r < 16; r++) begin
      logic [15:0] e;
      e = (r >= 4 && r <= 6) ? 16'h0001 : 16'h0000;
      checks++; if (got[r] !== e) begin errors++; $display("FAIL wrap_row%0d got %h want %h", r, got[r], e); end
    end
  endtask

  task automatic test_backpressure();
    int g;
    tmo = 0; hold_valid = 1;
    for (int r = 0; r < 16; r++) frame_in[r] = 16'($urandom);
    g = $urandom_range(2, 9);
    model_run(g);
    send_frame(8'(g));
    receive(1);
    hold_valid = 0;
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    for (int r = 0; r < 16; r++) begin
      checks++; if (got[r] !== exp_rows[r]) begin errors++; $display("FAIL bp_row%0d got %h want %h", r, got[r], exp_rows[r]); end
    end
    checks++; if (stab_bad) begin errors++; $display("FAIL bp_stall_stable got changed want held"); end
    checks++; if (inr_bad) begin errors++; $display("FAIL bp_in_ready got 1 want 0 while busy"); end
    checks++; if (post_bad) begin errors++; $display("FAIL bp_return_to_collect got bad want out_valid0 in_ready1"); end
    checks++; if (lat !== g + 3) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, g + 3); end
  endtask

  task automatic test_reset_in_run();
    bit stray;
    tmo = 0; hold_valid = 0;
    for (int r = 0; r < 16; r++) frame_in[r] = 16'($urandom);
    send_frame(8'd20);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstrun_ready_busy got %b%b want 10", in_ready, busy); end
    checks++; if (out_valid !== 1'b0 || life_load !== 1'b0 || out_last !== 1'b0 || out_row !== 16'h0) begin errors++; $display("FAIL rstrun_outputs got v%b l%b t%b r%h want zeros", out_valid, life_load, out_last, out_row); end
    checks++; if (life_data !== 256'h0) begin errors++; $display("FAIL rstrun_life_data got %h want 0", life_data); end
    stray = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1;
    end
    checks++; if (stray) begin errors++; $display("FAIL rstrun_stray_activity got 1 want 0"); end
    test_blinker();
  endtask

  task automatic test_random();
    int g, mode;
    hold_valid = 0;
    repeat (4) begin
      tmo = 0;
      for (int r = 0; r < 16; r++) frame_in[r] = 16'($urandom);
      g = $urandom_range(0, 12);
      mode = $urandom_range(1);
      model_run(g);
      send_frame(8'(g));
      receive(mode);
      checks++; if (tmo) begin errors++; $display("FAIL rand_timeout got 1 want 0"); end
      for (int r = 0; r < 16; r++) begin
        checks++; if (got[r] !== exp_rows[r]) begin errors++; $display("FAIL rand_g%0d_row%0d got %h want %h", g, r, got[r], exp_rows[r]); end
      end
      checks++; if (lat !== g + 3) begin errors++; $display("FAIL rand_latency got %0d want %0d", lat, g + 3); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blinker();
    test_identity();
    test_still_life();
    test_wrap();
    test_backpressure();
    test_reset_in_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
